// File: rtl/median_window_3x3.sv
// 3x3 window former for the median filter: two line buffers plus a registered window (MEDIAN_WIN_SOF_EN adds in_sof).
// Latency: window outputs register one clock after the bottom-right pixel is accepted.
// Backpressure: none; every in_valid pixel is accepted, idle cycles hold all state and the window outputs.
module median_window_3x3 #(
    parameter int PIX_W = 8,
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [PIX_W-1:0] in_pix,
`ifdef MEDIAN_WIN_SOF_EN
    input  logic             in_sof,
`endif
    output logic             out_valid,
    output logic             out_last,
    output logic [PIX_W-1:0] a1,
    output logic [PIX_W-1:0] a2,
    output logic [PIX_W-1:0] a3,
    output logic [PIX_W-1:0] a4,
    output logic [PIX_W-1:0] a5,
    output logic [PIX_W-1:0] a6,
    output logic [PIX_W-1:0] a7,
    output logic [PIX_W-1:0] a8,
    output logic [PIX_W-1:0] center
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    typedef logic [CW-1:0]      col_t;
    typedef logic [RW-1:0]      row_t;
    typedef logic [3*PIX_W-1:0] wcol_t;   // {top, mid, bottom}

    localparam col_t COL_LAST = col_t'(IMG_W - 1);
    localparam row_t ROW_LAST = row_t'(IMG_H - 1);
    localparam col_t COL_TWO  = col_t'(2);
    localparam row_t ROW_TWO  = row_t'(2);

    logic [PIX_W-1:0] lb0_q [IMG_W];
    logic [PIX_W-1:0] lb1_q [IMG_W];

    col_t  col_q, col_d, col_cur;
    row_t  row_q, row_d, row_cur;
    wcol_t wl_q, wm_q, wr_d;
    logic  sof, emit_d, last_d;
    logic  out_valid_q, out_last_q;
    logic [PIX_W-1:0] lb0_rd, lb1_rd;
    logic [PIX_W-1:0] a1_q, a2_q, a3_q, a4_q, a5_q, a6_q, a7_q, a8_q, center_q;

`ifdef MEDIAN_WIN_SOF_EN
    assign sof = in_valid & in_sof;
`else
    assign sof = 1'b0;
`endif

    always_comb begin
        col_cur = sof ? '0 : col_q;
        row_cur = sof ? '0 : row_q;
        lb0_rd  = lb0_q[col_cur];
        lb1_rd  = lb1_q[col_cur];
        wr_d    = {lb1_rd, lb0_rd, in_pix};
        col_d   = col_q;
        row_d   = row_q;
        if (in_valid) begin
            if (col_cur == COL_LAST) begin
                col_d = '0;
                row_d = (row_cur == ROW_LAST) ? '0 : row_t'(row_cur + 1'b1);
            end else begin
                col_d = col_t'(col_cur + 1'b1);
                row_d = row_cur;
            end
        end
        // Centre is (row-1, col-1): wl_q holds column col-2, wm_q column col-1.
        emit_d = in_valid && (row_cur >= ROW_TWO) && (col_cur >= COL_TWO);
        last_d = emit_d && (row_cur == ROW_LAST) && (col_cur == COL_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q       <= '0;
            row_q       <= '0;
            wl_q        <= '0;
            wm_q        <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            a1_q        <= '0;
            a2_q        <= '0;
            a3_q        <= '0;
            a4_q        <= '0;
            a5_q        <= '0;
            a6_q        <= '0;
            a7_q        <= '0;
            a8_q        <= '0;
            center_q    <= '0;
        end else begin
            out_valid_q <= emit_d;
            out_last_q  <= last_d;
            col_q       <= col_d;
            row_q       <= row_d;
            if (in_valid) begin
                wl_q <= wm_q;
                wm_q <= wr_d;
            end
            if (emit_d) begin
                a1_q     <= wl_q[3*PIX_W-1:2*PIX_W];
                a2_q     <= wm_q[3*PIX_W-1:2*PIX_W];
                a3_q     <= lb1_rd;
                a4_q     <= wl_q[2*PIX_W-1:PIX_W];
                center_q <= wm_q[2*PIX_W-1:PIX_W];
                a5_q     <= lb0_rd;
                a6_q     <= wl_q[PIX_W-1:0];
                a7_q     <= wm_q[PIX_W-1:0];
                a8_q     <= in_pix;
            end
        end
    end

    // Line buffers are deliberately unreset; rows < 2 never emit, so stale data is never seen.
    always_ff @(posedge clk) begin
        if (in_valid && !rst) begin
            lb1_q[col_cur] <= lb0_rd;
            lb0_q[col_cur] <= in_pix;
        end
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign a1        = a1_q;
    assign a2        = a2_q;
    assign a3        = a3_q;
    assign a4        = a4_q;
    assign a5        = a5_q;
    assign a6        = a6_q;
    assign a7        = a7_q;
    assign a8        = a8_q;
    assign center    = center_q;

endmodule

// File: tb/tb_median_window_3x3.sv
// Directed bench for median_window_3x3 on a 5x4 ramp frame (pixel = row*16+col + frame offset).
module tb_median_window_3x3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_pix = 8'h00;
`ifdef MEDIAN_WIN_SOF_EN
    logic       in_sof = 1'b0;
`endif
    logic       out_valid, out_last;
    logic [7:0] a1, a2, a3, a4, a5, a6, a7, a8, center;

    median_window_3x3 #(.PIX_W(8), .IMG_W(5), .IMG_H(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_pix(in_pix),
`ifdef MEDIAN_WIN_SOF_EN
        .in_sof(in_sof),
`endif
        .out_valid(out_valid), .out_last(out_last),
        .a1(a1), .a2(a2), .a3(a3), .a4(a4), .a5(a5), .a6(a6), .a7(a7), .a8(a8),
        .center(center)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] trig_r;
        logic [2:0] trig_c;
        logic [7:0] a1, a2, a3, a4, a5, a6, a7, a8, c;
        logic       last;
    } win_t;

    win_t       exp_tab [6];
    int         n_vec = 0;
    int         n_err = 0;
    int         widx  = 0;
    logic [7:0] base  = 8'h00;
    logic [7:0] snap_c  = 8'h00;
    logic [7:0] snap_a1 = 8'h00;
    logic [7:0] snap_a8 = 8'h00;

    task automatic chk(input string name, input int act, input int req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Drive one cycle, then check what the DUT shows right after that edge.
    task automatic px(input logic vld, input logic [7:0] pix, input logic sof, input int r, input int c);
        win_t e;
        in_valid = vld;
        in_pix   = pix;
`ifdef MEDIAN_WIN_SOF_EN
        in_sof   = sof;
`else
        if (sof) chk("sof_without_port", 1, 0);
`endif
        @(posedge clk);
        #1;
        if (out_valid) begin
            chk("pulse_after_idle", int'(vld), 1);
            if (widx < 6) begin
                e = exp_tab[widx];
                chk("trig_pos", r * 8 + c, int'(e.trig_r) * 8 + int'(e.trig_c));
                chk("a1", a1, 8'(e.a1 + base));
                chk("a2", a2, 8'(e.a2 + base));
                chk("a3", a3, 8'(e.a3 + base));
                chk("a4", a4, 8'(e.a4 + base));
                chk("a5", a5, 8'(e.a5 + base));
                chk("a6", a6, 8'(e.a6 + base));
                chk("a7", a7, 8'(e.a7 + base));
                chk("a8", a8, 8'(e.a8 + base));
                chk("center", center, 8'(e.c + base));
                chk("last", out_last, e.last);
                snap_c  = 8'(e.c + base);
                snap_a1 = 8'(e.a1 + base);
                snap_a8 = 8'(e.a8 + base);
            end else begin
                chk("extra_pulse", widx, 5);
            end
            widx++;
        end else begin
            chk("hold_center", center, snap_c);
            chk("hold_a1", a1, snap_a1);
            chk("hold_a8", a8, snap_a8);
            chk("last_without_valid", out_last, 0);
        end
    endtask

    task automatic frame(input logic [7:0] b, input bit gaps, input bit sof);
        logic [7:0] p;
        base = b;
        widx = 0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 5; c++) begin
                if (gaps) begin
                    int n;
                    n = $urandom_range(0, 2);
                    for (int k = 0; k < n; k++) px(1'b0, 8'hFF, 1'b0, r, c);
                end
                p = 8'(b + 8'(r * 16 + c));
                px(1'b1, p, sof && r == 0 && c == 0, r, c);
            end
        end
        chk("pulse_count", widx, 6);
    endtask

    task automatic do_reset(input logic vld);
        rst      = 1'b1;
        in_valid = vld;
        in_pix   = 8'h55;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_center", center, 0);
        chk("rst_a1", a1, 0);
        chk("rst_a5", a5, 0);
        chk("rst_a8", a8, 0);
        snap_c  = 8'h00;
        snap_a1 = 8'h00;
        snap_a8 = 8'h00;
    endtask

    initial begin
        //             trig  a1     a2     a3     a4     a5     a6     a7     a8     c      last
        exp_tab[0] = '{3'd2, 3'd2, 8'h00, 8'h01, 8'h02, 8'h10, 8'h12, 8'h20, 8'h21, 8'h22, 8'h11, 1'b0};
        exp_tab[1] = '{3'd2, 3'd3, 8'h01, 8'h02, 8'h03, 8'h11, 8'h13, 8'h21, 8'h22, 8'h23, 8'h12, 1'b0};
        exp_tab[2] = '{3'd2, 3'd4, 8'h02, 8'h03, 8'h04, 8'h12, 8'h14, 8'h22, 8'h23, 8'h24, 8'h13, 1'b0};
        exp_tab[3] = '{3'd3, 3'd2, 8'h10, 8'h11, 8'h12, 8'h20, 8'h22, 8'h30, 8'h31, 8'h32, 8'h21, 1'b0};
        exp_tab[4] = '{3'd3, 3'd3, 8'h11, 8'h12, 8'h13, 8'h21, 8'h23, 8'h31, 8'h32, 8'h33, 8'h22, 1'b0};
        exp_tab[5] = '{3'd3, 3'd4, 8'h12, 8'h13, 8'h14, 8'h22, 8'h24, 8'h32, 8'h33, 8'h34, 8'h23, 1'b1};

        @(posedge clk);
        do_reset(1'b0);
        px(1'b0, 8'h00, 1'b0, 0, 0);

        frame(8'h00, 1'b0, 1'b0);   // continuous ramp frame
        frame(8'h00, 1'b1, 1'b0);   // same frame with random idle gaps
        frame(8'h00, 1'b0, 1'b0);   // back-to-back frames, second offset by 0x80
        frame(8'h80, 1'b0, 1'b0);

        // Reset after 8 pixels, with in_valid also high on the reset edge.
        base = 8'h00;
        widx = 0;
        for (int i = 0; i < 8; i++) px(1'b1, 8'(8'hA0 + i), 1'b0, i / 5, i % 5);
        chk("partial_no_pulse", widx, 0);
        do_reset(1'b1);
        frame(8'h00, 1'b0, 1'b0);

`ifdef MEDIAN_WIN_SOF_EN
        base = 8'h00;
        widx = 0;
        for (int i = 0; i < 3; i++) px(1'b1, 8'(8'hE0 + i), 1'b0, 0, 0);
        frame(8'h00, 1'b0, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
